// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of saturating counters.
// Latency: prediction is combinational in the fetch cycle; training and history changes take effect at the next edge.
// Backpressure: stall freezes history and counters (the init sweep still runs); ready stays low until the sweep completes.
module gshare_branch_predictor #(
    parameter int PC_WIDTH       = 16,
    parameter int PC_LSB         = 1,
    parameter int PHT_INDEX_BITS = 8,
    parameter int GHR_SIZE       = 8,
    parameter int COUNTER_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                predict_valid,
    input  logic [PC_WIDTH-1:0] predict_pc,
    output logic                prediction,
    output logic [GHR_SIZE-1:0] predict_ghr,
    input  logic                update,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic [GHR_SIZE-1:0] update_ghr,
    input  logic                update_taken,
    input  logic                update_mispredict,
    output logic                ready
);

    localparam int DEPTH = 1 << PHT_INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = {1'b0, {(COUNTER_BITS-1){1'b1}}};

    typedef enum logic {INIT, RUN} state_t;

    state_t                    state, state_next;
    logic [PHT_INDEX_BITS-1:0] ptr;
    logic [GHR_SIZE-1:0]       ghr;
    logic [COUNTER_BITS-1:0]   pht [DEPTH];

    logic [PHT_INDEX_BITS-1:0] idx_pred, idx_upd;
    logic [COUNTER_BITS-1:0]   cnt_upd, cnt_next;
    logic                      pred_raw;
    logic [GHR_SIZE-1:0]       ghr_repair, ghr_spec;
    logic                      run_active;

    // Index generation: GHR is zero-extended to the index width before the xor
    always_comb begin
        idx_pred = predict_pc[PC_LSB +: PHT_INDEX_BITS] ^ PHT_INDEX_BITS'(ghr);
        idx_upd  = update_pc[PC_LSB +: PHT_INDEX_BITS] ^ PHT_INDEX_BITS'(update_ghr);
        pred_raw = pht[idx_pred][COUNTER_BITS-1];
        cnt_upd  = pht[idx_upd];
        run_active = (state == RUN) && !stall;
    end

    // Saturating increment/decrement of the resolved branch's counter
    always_comb begin
        cnt_next = cnt_upd;
        if (update_taken) begin
            if (cnt_upd != CNT_MAX) cnt_next = cnt_upd + 1'b1;
        end else begin
            if (cnt_upd != '0) cnt_next = cnt_upd - 1'b1;
        end
    end

    // History candidates; a one-bit history simply becomes the new outcome
    generate
        if (GHR_SIZE == 1) begin : g_ghr1
            always_comb begin
                ghr_repair = update_taken;
                ghr_spec   = pred_raw;
            end
        end else begin : g_ghrn
            always_comb begin
                ghr_repair = {update_ghr[GHR_SIZE-2:0], update_taken};
                ghr_spec   = {ghr[GHR_SIZE-2:0], pred_raw};
            end
        end
    endgenerate

    // State register, sweep pointer and global history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
            ghr   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) ptr <= ptr + 1'b1;
            if (run_active) begin
                if (update && update_mispredict) ghr <= ghr_repair;
                else if (predict_valid)          ghr <= ghr_spec;
            end
        end
    end

    // Next state: leave the sweep after the last entry is written; RUN is terminal
    always_comb begin
        state_next = state;
        if (state == INIT && ptr == PHT_INDEX_BITS'(DEPTH - 1)) state_next = RUN;
    end

    // Outputs are forced low until the table has been initialised
    always_comb begin
        ready       = (state == RUN);
        prediction  = ready && pred_raw;
        predict_ghr = ready ? ghr : '0;
    end

    // Single write port: sweep writes during INIT, training writes during RUN
    always_ff @(posedge clk) begin
        if (state == INIT)             pht[ptr]     <= CNT_INIT;
        else if (update && !stall)     pht[idx_upd] <= cnt_next;
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        predict_valid;
    logic [15:0] predict_pc;
    logic        prediction;
    logic [7:0]  predict_ghr;
    logic        update;
    logic [15:0] update_pc;
    logic [7:0]  update_ghr;
    logic        update_taken;
    logic        update_mispredict;
    logic        ready;

    gshare_branch_predictor dut (
        .clk(clk), .rst(rst), .stall(stall),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .prediction(prediction), .predict_ghr(predict_ghr),
        .update(update), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic       pred;
        logic [7:0] ghr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counter values as integers, history as an integer
    int m_cnt [256];
    int m_ghr;
    int m_edges;

    function automatic int m_idx(input int pc, input int g);
        return ((pc >> 1) % 256) ^ g;
    endfunction

    task automatic m_reset();
        m_ghr   = 0;
        m_edges = 0;
        for (int i = 0; i < 256; i++) m_cnt[i] = 1;
    endtask

    // Drive one cycle of inputs, push the expected outputs, then advance the model past the coming edge
    task automatic step(input logic rs, input logic st, input logic pv, input int ppc,
                        input logic up, input int upc, input int ughr,
                        input logic ut, input logic um);
        exp_t e;
        logic rdy_m;
        int   p;
        @(posedge clk);
        #1;
        rst = rs; stall = st; predict_valid = pv; predict_pc = 16'(ppc);
        update = up; update_pc = 16'(upc); update_ghr = 8'(ughr);
        update_taken = ut; update_mispredict = um;
        if (rs) m_reset();
        rdy_m = (m_edges >= 256);
        p = (rdy_m && m_cnt[m_idx(ppc, m_ghr)] >= 2) ? 1 : 0;
        e.rdy  = rdy_m;
        e.pred = (p != 0);
        e.ghr  = rdy_m ? 8'(m_ghr) : 8'h00;
        exp_q.push_back(e);
        if (!rs) begin
            if (!rdy_m) begin
                m_edges++;
            end else if (!st) begin
                if (up) begin
                    int k = m_idx(upc, ughr);
                    if (ut) m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
                    else    m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
                end
                if (up && um)  m_ghr = ((ughr << 1) | (ut ? 1 : 0)) % 256;
                else if (pv)   m_ghr = ((m_ghr << 1) | p) % 256;
            end
        end
    endtask

    task automatic idle(input logic st);
        step(1'b0, st, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents ready/prediction/history, compared away from the edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (ready !== e.rdy) begin
                errors++;
                $display("FAIL ready @%0t: got %b expected %b", $time, ready, e.rdy);
            end
            checks++;
            if (prediction !== e.pred) begin
                errors++;
                $display("FAIL prediction @%0t pc=%h: got %b expected %b", $time, predict_pc, prediction, e.pred);
            end
            checks++;
            if (predict_ghr !== e.ghr) begin
                errors++;
                $display("FAIL predict_ghr @%0t: got %h expected %h", $time, predict_ghr, e.ghr);
            end
        end
    end

    // Release reset and measure the sweep length directly
    task automatic sweep_and_time();
        int n = 0;
        idle(1'b0);
        while (!ready && n < 400) begin
            if (n == 10) step(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0010, 0, 1'b1, 1'b1);
            else         idle(1'b0);
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL sweep_length: got %0d cycles expected 256", n);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; predict_valid = 1'b0; predict_pc = '0;
        update = 1'b0; update_pc = '0; update_ghr = '0;
        update_taken = 1'b0; update_mispredict = 1'b0;
        m_reset();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 0, 0, 1'b0, 1'b0);

        // Reset mid-sweep, then a full sweep
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        sweep_and_time();

        // Training pc 0x0004 with GHR 0: weakly not-taken, then saturate
        step(1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        sweep_and_time();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0004, 0, 1'b1, 1'b0);
        idle(1'b0);

        // Stalled predictions must not shift history
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 0, 0, 1'b0, 1'b0);
        // Speculative shifts with taken predictions: 0x01, 0x03, 0x07
        step(1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, 16'h0006, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, 16'h0006, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0006, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0002, 3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0002, 3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(1'b0);
        // Repair beats a same-cycle prediction: GHR 0x07 -> 0x04
        step(1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0040, 8'h02, 1'b0, 1'b1);
        idle(1'b0);
        // Same-cycle read/write to one index: old value now, new value next cycle
        step(1'b0, 1'b0, 1'b0, 16'h0010, 1'b1, 16'h0010, 8'h04, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 0, 0, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 65535)), $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        // Force GHR to 0x5A by repair, reset during RUN, re-sweep and read back every counter
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h0100, 8'h2D, 1'b0, 1'b1);
        idle(1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        sweep_and_time();
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0, 1'b0, i * 2, 1'b1, i * 2, 0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, i * 2, 1'b0, 0, 0, 1'b0, 1'b0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
